multicyc_mcu: RTL and testbench
===============================

# multicyc_mcu

Moore-style control FSM that sequences a multi-cycle MIPS datapath: one shared memory, instruction register, ALU reused for PC increment and branch target. Decodes `opcode` and drives every datapath mux select and write enable per state. It feeds `aluop` into the existing `alu_cu` and takes `eq` from the `alu`. Supports R-type, lw, sw, beq, addi and j; any other opcode halts the core.

## Interface
- `ST_W`, default 4: state register width; `state_debug` width.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instr[31:26] taken from the instruction register.
- `eq`  in  1  ALU equality flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_we`  out  1  memory write enable.
- `ir_we`  out  1  instruction register load.
- `pc_en`  out  1  PC register load.
- `pc_src`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_srca_sel`  out  1  0 = PC, 1 = register A.
- `alu_srcb_sel`  out  2  00 = register B, 01 = const 4, 10 = sign_imm, 11 = sign_imm<<2.
- `aluop`  out  4  0000 = add, 0001 = sub, 0010 = decode funct.
- `reg_we`  out  1  register file write enable.
- `wreg_dst_sel`  out  1  1 = rd, 0 = rt.
- `wreg_data_sel`  out  1  1 = memory data register, 0 = ALUOut.
- `illegal_op`  out  1  high while in HALT.
- `state_debug`  out  ST_W  current state code.

## Operation
- State codes and next-state rules:
  - FETCH=0: go to DECODE on `mem_ready`.
  - DECODE=1: dispatch on `opcode`.
    - 100011 or 101011 -> MEMADR.
    - 000000 -> EXEC.
    - 000100 -> BRANCH.
    - 001000 -> ADDIEX.
    - 000010 -> JUMP.
    - Any other -> HALT.
  - MEMADR=2: lw -> MEMRD, sw -> MEMWR.
  - MEMRD=3: go to MEMWB on `mem_ready`.
  - MEMWB=4: go to FETCH.
  - MEMWR=5: go to FETCH on `mem_ready`.
  - EXEC=6: go to ALUWB.
  - ALUWB=7: go to FETCH.
  - BRANCH=8: go to FETCH.
  - ADDIEX=9: go to ADDIWB.
  - ADDIWB=10: go to FETCH.
  - JUMP=11: go to FETCH.
  - HALT=15: terminal; only reset exits.
- Any unused code (12-14) returns to FETCH on the next edge.
- Outputs per state; anything not listed is 0.
  - FETCH: srcb=01, aluop=add, pc_src=00, `ir_we` = `pc_en` = `mem_ready`.
  - DECODE: srcb=11, aluop=add (branch target into ALUOut).
  - MEMADR: srca=1, srcb=10, add.
  - MEMRD: iord=1.
  - MEMWB: reg_we=1, wreg_data_sel=1, wreg_dst_sel=0.
  - MEMWR: iord=1, mem_we=1; held until `mem_ready`.
  - EXEC: srca=1, srcb=00, aluop=0010.
  - ALUWB: reg_we=1, wreg_dst_sel=1, wreg_data_sel=0.
  - BRANCH: srca=1, srcb=00, sub, pc_src=01, `pc_en` = `eq`.
  - ADDIEX: srca=1, srcb=10, add.
  - ADDIWB: reg_we=1, dst=0, data=0.
  - JUMP: pc_src=10, pc_en=1.
  - HALT: `illegal_op`=1, all enables 0.
- `opcode` is sampled only in DECODE and MEMADR. The IR is stable in both.

## Timing
- Reset:
  - `reset_n` low forces state to FETCH immediately (asynchronous).
  - While `reset_n`=0: `mem_we`, `ir_we`, `pc_en`, `reg_we` = 0; `illegal_op`=0; `state_debug`=0.
  - Other outputs take their FETCH values.
  - Reset asserted mid-instruction aborts it; no partial write follows deassertion.
- Outputs are combinational from the state register; `pc_en` and `ir_we` also depend on `eq` / `mem_ready`.
- Zero-wait cycles per instruction: R 4, lw 5, sw 4, beq 3, addi 4, j 3.
- Each wait cycle (`mem_ready`=0) in FETCH, MEMRD or MEMWR adds one cycle. No enable fires during the wait, except `mem_we` in MEMWR, which is held.
- First FETCH after reset release begins on the first rising edge with `reset_n`=1.

## Configuration
- `MULTICYC_MCU_MEM_WAIT_EN` defined: `mem_ready` is honoured as described above.
- Not defined: `mem_ready` is ignored and treated as 1. Every memory state lasts exactly one cycle and the port is left unconnected internally.

## Test plan
- Reset then opcode=000000, `mem_ready`=1 -> `state_debug` 0,1,6,7,0. `reg_we`=1 with `wreg_dst_sel`=1 only in cycle 4.
- opcode=100011 with `mem_ready` low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. `iord`=1 throughout MEMRD; `reg_we` only in MEMWB.
- opcode=000100, `eq`=1 then a second run with `eq`=0 -> `pc_en`=1 with `pc_src`=01 in BRANCH for the first run; `pc_en`=0 for the second.
- opcode=101011 with `mem_ready`=0 for 1 cycle in MEMWR -> `mem_we`=1 for 2 consecutive cycles, then FETCH.
- opcode=111111 -> HALT (15), `illegal_op`=1 held for 10 cycles. Pulsing `reset_n` low returns to state 0 with `illegal_op`=0.
- Assert `reset_n` low during ADDIEX -> state 0 within the same cycle with all enables 0. The next instruction fetch is clean.

Source files
------------

// File: rtl/multicyc_mcu.sv
// Multi-cycle MIPS control FSM (R-type, lw, sw, beq, addi, j; others halt).
// Optional: define MULTICYC_MCU_MEM_WAIT_EN to honour mem_ready wait states;
// otherwise every memory state completes in one cycle.
module multicyc_mcu #(
  parameter int unsigned ST_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [5:0]      opcode,
  input  logic            eq,
  input  logic            mem_ready,
  output logic            iord,
  output logic            mem_we,
  output logic            ir_we,
  output logic            pc_en,
  output logic [1:0]      pc_src,
  output logic            alu_srca_sel,
  output logic [1:0]      alu_srcb_sel,
  output logic [3:0]      aluop,
  output logic            reg_we,
  output logic            wreg_dst_sel,
  output logic            wreg_data_sel,
  output logic            illegal_op,
  output logic [ST_W-1:0] state_debug
);

  typedef enum logic [ST_W-1:0] {
    FETCH  = ST_W'(0),
    DECODE = ST_W'(1),
    MEMADR = ST_W'(2),
    MEMRD  = ST_W'(3),
    MEMWB  = ST_W'(4),
    MEMWR  = ST_W'(5),
    EXEC   = ST_W'(6),
    ALUWB  = ST_W'(7),
    BRANCH = ST_W'(8),
    ADDIEX = ST_W'(9),
    ADDIWB = ST_W'(10),
    JUMP   = ST_W'(11),
    HALT   = ST_W'(15)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;

  state_t state_q;
  state_t state_d;
  logic   mem_rdy;

`ifdef MULTICYC_MCU_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_rdy          = 1'b1;
`endif

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_rdy) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = HALT;
        endcase
      end
      MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_rdy) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem_rdy) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      ADDIEX: state_d = ADDIWB;
      ADDIWB: state_d = FETCH;
      JUMP:   state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Per-state datapath controls. FETCH enables are gated by reset_n so
  // nothing loads while reset is held (state already reads FETCH then).
  always_comb begin
    iord          = 1'b0;
    mem_we        = 1'b0;
    ir_we         = 1'b0;
    pc_en         = 1'b0;
    pc_src        = 2'b00;
    alu_srca_sel  = 1'b0;
    alu_srcb_sel  = 2'b00;
    aluop         = ALU_ADD;
    reg_we        = 1'b0;
    wreg_dst_sel  = 1'b0;
    wreg_data_sel = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      FETCH: begin
        alu_srcb_sel = 2'b01;
        ir_we        = mem_rdy & reset_n;
        pc_en        = mem_rdy & reset_n;
      end
      DECODE: alu_srcb_sel = 2'b11;
      MEMADR: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        reg_we        = 1'b1;
        wreg_data_sel = 1'b1;
      end
      MEMWR: begin
        iord   = 1'b1;
        mem_we = 1'b1;
      end
      EXEC: begin
        alu_srca_sel = 1'b1;
        aluop        = ALU_FUNCT;
      end
      ALUWB: begin
        reg_we       = 1'b1;
        wreg_dst_sel = 1'b1;
      end
      BRANCH: begin
        alu_srca_sel = 1'b1;
        aluop        = ALU_SUB;
        pc_src       = 2'b01;
        pc_en        = eq;
      end
      ADDIEX: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = 2'b10;
      end
      ADDIWB: reg_we = 1'b1;
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      HALT: illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign state_debug = state_q;

endmodule

// File: tb/tb_multicyc_mcu.sv
// Self-checking bench for multicyc_mcu: directed instruction table, hand-written
// halt/reset-abort sequences, then random instruction streams against an
// instruction-level reference model.
module tb_multicyc_mcu;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       eq;
  logic       mem_ready;
  logic       iord, mem_we, ir_we, pc_en;
  logic [1:0] pc_src;
  logic       alu_srca_sel;
  logic [1:0] alu_srcb_sel;
  logic [3:0] aluop;
  logic       reg_we, wreg_dst_sel, wreg_data_sel, illegal_op;
  logic [3:0] state_debug;

  always #5 clk = ~clk;

  multicyc_mcu #(.ST_W(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .eq            (eq),
    .mem_ready     (mem_ready),
    .iord          (iord),
    .mem_we        (mem_we),
    .ir_we         (ir_we),
    .pc_en         (pc_en),
    .pc_src        (pc_src),
    .alu_srca_sel  (alu_srca_sel),
    .alu_srcb_sel  (alu_srcb_sel),
    .aluop         (aluop),
    .reg_we        (reg_we),
    .wreg_dst_sel  (wreg_dst_sel),
    .wreg_data_sel (wreg_data_sel),
    .illegal_op    (illegal_op),
    .state_debug   (state_debug)
  );

`ifdef MULTICYC_MCU_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct packed {
    logic       iord;
    logic       mem_we;
    logic       ir_we;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       srca;
    logic [1:0] srcb;
    logic [3:0] aluop;
    logic       reg_we;
    logic       dst;
    logic       data;
    logic       illegal;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
  } step_t;

  typedef struct {
    logic [5:0]  op;
    logic        eq;
    int unsigned wf;
    int unsigned wm;
    int unsigned base;
  } vec_t;

  int    vectors    = 0;
  int    miscompares = 0;
  step_t path[$];

  // Expected control word for a state code, from the per-state output table.
  function automatic outs_t exp_out(input logic [3:0] st, input logic eq_v,
                                    input logic rdy_v, input logic rst_v);
    outs_t o;
    o = '0;
    o.state = st;
    if (!rst_v) begin
      o.state = 4'd0;
      o.srcb  = 2'b01;
      return o;
    end
    case (st)
      4'd0:  begin o.srcb = 2'b01; o.ir_we = rdy_v; o.pc_en = rdy_v; end
      4'd1:  o.srcb = 2'b11;
      4'd2:  begin o.srca = 1'b1; o.srcb = 2'b10; end
      4'd3:  o.iord = 1'b1;
      4'd4:  begin o.reg_we = 1'b1; o.data = 1'b1; end
      4'd5:  begin o.iord = 1'b1; o.mem_we = 1'b1; end
      4'd6:  begin o.srca = 1'b1; o.aluop = 4'b0010; end
      4'd7:  begin o.reg_we = 1'b1; o.dst = 1'b1; end
      4'd8:  begin o.srca = 1'b1; o.aluop = 4'b0001; o.pc_src = 2'b01; o.pc_en = eq_v; end
      4'd9:  begin o.srca = 1'b1; o.srcb = 2'b10; end
      4'd10: o.reg_we = 1'b1;
      4'd11: begin o.pc_src = 2'b10; o.pc_en = 1'b1; end
      4'd15: o.illegal = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic int unsigned base_cycles(input logic [5:0] op);
    case (op)
      6'b000000: return 4;
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000100: return 3;
      6'b001000: return 4;
      6'b000010: return 3;
      default:   return 0;
    endcase
  endfunction

  task automatic check(input string name, input outs_t e);
    outs_t a;
    a = {iord, mem_we, ir_we, pc_en, pc_src, alu_srca_sel, alu_srcb_sel, aluop,
         reg_we, wreg_dst_sel, wreg_data_sel, illegal_op, state_debug};
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h (state %0d) expected %h (state %0d)",
               name, $time, a, a.state, e, e.state);
    end
  endtask

  task automatic check_cycles(input string name, input int unsigned got, input int unsigned want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: cycles got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected state walk of one instruction, with the mem_ready to drive each cycle.
  task automatic build_path(input logic [5:0] op, input int unsigned wf, input int unsigned wm);
    logic [3:0] ms;
    path.delete();
    if (WAIT_EN) begin
      for (int unsigned k = 0; k < wf; k++) path.push_back('{4'd0, 1'b0});
      path.push_back('{4'd0, 1'b1});
    end else begin
      path.push_back('{4'd0, rbit()});
    end
    path.push_back('{4'd1, rbit()});
    case (op)
      6'b100011, 6'b101011: begin
        path.push_back('{4'd2, rbit()});
        ms = (op == 6'b100011) ? 4'd3 : 4'd5;
        if (WAIT_EN) begin
          for (int unsigned k = 0; k < wm; k++) path.push_back('{ms, 1'b0});
          path.push_back('{ms, 1'b1});
        end else begin
          path.push_back('{ms, rbit()});
        end
        if (op == 6'b100011) path.push_back('{4'd4, rbit()});
      end
      6'b000000: begin path.push_back('{4'd6, rbit()}); path.push_back('{4'd7, rbit()}); end
      6'b000100: path.push_back('{4'd8, rbit()});
      6'b001000: begin path.push_back('{4'd9, rbit()}); path.push_back('{4'd10, rbit()}); end
      6'b000010: path.push_back('{4'd11, rbit()});
      default:   path.push_back('{4'd15, rbit()});
    endcase
  endtask

  // Called between a falling edge and the next rising edge.
  task automatic pulse_reset();
    mem_ready = 1'b1;
    eq        = 1'b1;
    opcode    = 6'($urandom);
    reset_n   = 1'b0;
    #1;
    check("reset_assert", exp_out(4'd0, 1'b1, 1'b1, 1'b0));
    @(negedge clk);
    #1;
    check("reset_hold", exp_out(4'd0, 1'b1, 1'b1, 1'b0));
    reset_n = 1'b1;
  endtask

  // Runs one instruction cycle by cycle; returns the cycles until the DUT is
  // seen back in FETCH (0 if it never returned within the walk).
  task automatic run_instr(input logic [5:0] op, input logic eq_i,
                           input int unsigned wf, input int unsigned wm,
                           input int abort_st, output int unsigned measured);
    bit         done;
    logic [3:0] st;
    build_path(op, wf, wm);
    measured = 0;
    done     = 1'b0;
    for (int i = 0; i < path.size(); i++) begin
      st        = path[i].st;
      opcode    = (st == 4'd1 || st == 4'd2) ? op : 6'($urandom);
      eq        = (st == 4'd8) ? eq_i : rbit();
      mem_ready = path[i].rdy;
      #1;
      check($sformatf("op%b step%0d", op, i),
            exp_out(st, eq, WAIT_EN ? mem_ready : 1'b1, 1'b1));
      if (int'(st) == abort_st) begin
        pulse_reset();
        return;
      end
      @(negedge clk);
      if (!done && state_debug == 4'd0) begin
        measured = i + 1;
        done     = 1'b1;
      end
    end
  endtask

  initial begin
    vec_t          tbl[8];
    int unsigned   m;
    logic [5:0]    legal [6];
    logic [5:0]    op;
    int unsigned   wf, wm, want;

    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

    tbl[0] = '{6'b000000, 1'b0, 0, 0, 4};
    tbl[1] = '{6'b100011, 1'b0, 0, 2, 5};
    tbl[2] = '{6'b101011, 1'b0, 0, 1, 4};
    tbl[3] = '{6'b000100, 1'b1, 0, 0, 3};
    tbl[4] = '{6'b000100, 1'b0, 0, 0, 3};
    tbl[5] = '{6'b001000, 1'b0, 1, 0, 4};
    tbl[6] = '{6'b000010, 1'b0, 0, 0, 3};
    tbl[7] = '{6'b100011, 1'b1, 1, 1, 5};

    reset_n   = 1'b0;
    mem_ready = 1'b1;
    eq        = 1'b1;
    opcode    = 6'b0;
    @(negedge clk);
    pulse_reset();

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].eq, tbl[i].wf, tbl[i].wm, -1, m);
      want = tbl[i].base + (WAIT_EN ? tbl[i].wf + tbl[i].wm : 0);
      check_cycles($sformatf("table%0d", i), m, want);
    end

    // Illegal opcode: HALT is sticky until reset.
    run_instr(6'b111111, 1'b0, 0, 0, -1, m);
    for (int i = 0; i < 10; i++) begin
      opcode    = 6'($urandom);
      eq        = rbit();
      mem_ready = rbit();
      #1;
      check($sformatf("halt%0d", i), exp_out(4'd15, eq, 1'b1, 1'b1));
      @(negedge clk);
    end
    pulse_reset();
    run_instr(6'b000000, 1'b0, 0, 0, -1, m);
    check_cycles("after_halt", m, 4);

    // Reset during ADDIEX, then a clean instruction.
    run_instr(6'b001000, 1'b0, 0, 0, 9, m);
    run_instr(6'b001000, 1'b0, 0, 0, -1, m);
    check_cycles("after_abort", m, 4);

    for (int n = 0; n < 150; n++) begin
      op = legal[$urandom_range(0, 5)];
      wf = $urandom_range(0, 2);
      wm = (op == 6'b100011 || op == 6'b101011) ? $urandom_range(0, 2) : 0;
      run_instr(op, rbit(), wf, wm, -1, m);
      want = base_cycles(op) + (WAIT_EN ? wf + wm : 0);
      check_cycles($sformatf("rand%0d", n), m, want);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
